// File: rtl/compare_serial.sv
// Multi-cycle magnitude comparator: one 4-bit slice walks the operands MSB nibble first.
// Optional build macro COMPARE_SERIAL_EARLY_EXIT_EN stops at the first unequal nibble.

module compare_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       equal,
  output logic       blarger
);
  assign equal   = (a == b);
  assign blarger = (b > a);
endmodule

module compare_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             unsigned_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic             equal_o,
  output logic             less_o
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);
  localparam logic [IW-1:0] IDX_TOP = IW'(NIB - 1);

`ifdef COMPARE_SERIAL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic             decided, eq_acc, lt_acc;
  logic [3:0]       a_nib, b_nib;
  logic             cmp_eq, cmp_bl;
  logic             nxt_decided, nxt_eq, nxt_lt, exit_now;
  logic [WIDTH-1:0] sign_flip;

  assign a_nib = a_q[{idx, 2'b00} +: 4];
  assign b_nib = b_q[{idx, 2'b00} +: 4];

  compare_4bit u_slice (
    .a       (a_nib),
    .b       (b_nib),
    .equal   (cmp_eq),
    .blarger (cmp_bl)
  );

  // Signed compare becomes unsigned once both sign bits are inverted (offset binary).
  assign sign_flip = {~unsigned_i, {(WIDTH-1){1'b0}}};

  always_comb begin
    nxt_decided = decided | ~cmp_eq;
    nxt_eq      = decided ? eq_acc : cmp_eq;
    nxt_lt      = decided ? lt_acc : (~cmp_eq & cmp_bl);
    exit_now    = (idx == '0) || (EARLY && !decided && !cmp_eq);
  end

  assign ready_o = (state == IDLE) || (state == DONE);
  assign busy_o  = (state == RUN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      valid_o <= 1'b0;
      equal_o <= 1'b0;
      less_o  <= 1'b0;
      idx     <= IDX_TOP;
      decided <= 1'b0;
      eq_acc  <= 1'b0;
      lt_acc  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            a_q     <= a_i ^ sign_flip;
            b_q     <= b_i ^ sign_flip;
            idx     <= IDX_TOP;
            decided <= 1'b0;
            eq_acc  <= 1'b1;
            lt_acc  <= 1'b0;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          decided <= nxt_decided;
          eq_acc  <= nxt_eq;
          lt_acc  <= nxt_lt;
          if (idx != '0) idx <= idx - IW'(1);
          if (exit_now) begin
            equal_o <= nxt_eq;
            less_o  <= nxt_lt;
            valid_o <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_compare_serial.sv
// Scoreboard bench for compare_serial: directed cases plus randomized operands.
module tb_compare_serial;
  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;
`ifdef COMPARE_SERIAL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk, rst, start, uns;
  logic [WIDTH-1:0] a_in, b_in;
  logic             ready_o, busy_o, valid_o, equal_o, less_o;

  compare_serial #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .a_i        (a_in),
    .b_i        (b_in),
    .unsigned_i (uns),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .equal_o    (equal_o),
    .less_o     (less_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic eq;
    logic lt;
    int   at;
  } exp_t;
  exp_t q[$];

  int nvec = 0;
  int nfail = 0;

  function automatic void chk(string name, int act, int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Number of nibbles the comparator must look at for this operand pair.
  function automatic int nibbles_used(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    d = a ^ b;
    if (!EARLY) return NIB;
    for (int k = NIB - 1; k >= 0; k--)
      if (((d >> (4 * k)) & 32'hF) != 0) return NIB - k;
    return NIB;
  endfunction

  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_valid: got valid_o=1, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("equal", int'(equal_o), int'(e.eq));
        chk("less", int'(less_o), int'(e.lt));
        chk("valid_cycle", cyc, e.at);
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit u, input bit push, output int done_at);
    exp_t e;
    chk("ready_at_start", int'(ready_o), 1);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    uns   = u;
    done_at = cyc + 1 + nibbles_used(a, b);
    if (push) begin
      e.eq = (a == b);
      e.lt = u ? (a < b) : ($signed(a) < $signed(b));
      e.at = done_at;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    uns   = 1'($urandom);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int d, d2, t0, k, sel;
    logic [WIDTH-1:0] ra, rb;
    logic [3:0] n;
    rst = 1'b1; start = 1'b0; uns = 1'b1; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", int'(ready_o), 1);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_equal", int'(equal_o), 0);
    chk("reset_less", int'(less_o), 0);
    rst = 1'b0;
    @(negedge clk);

    // equal operands, then unsigned/signed MSB cases, then an early mismatch
    issue(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, d); wait_to(d + 1);
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, d); wait_to(d + 1);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, d); wait_to(d + 1);
    issue(32'h1000_0000, 32'h2000_0000, 1'b1, 1'b1, d); wait_to(d + 1);

    // back-to-back start during DONE
    issue(32'hFFFF_FFF3, 32'hFFFF_FFF5, 1'b0, 1'b1, d); wait_to(d);
    issue(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, d); wait_to(d + 1);

    // start during RUN must be ignored
    issue(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, d);
    @(negedge clk);
    chk("busy_during_run", int'(busy_o), 1);
    chk("not_ready_during_run", int'(ready_o), 0);
    start = 1'b1; a_in = 32'h0000_0001; b_in = 32'hFFFF_FFFF; uns = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_to(d + 1);

    // reset mid-RUN aborts (previous result left equal_o=1)
    issue(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 1'b0, d2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", int'(ready_o), 1);
    chk("abort_equal", int'(equal_o), 0);
    chk("abort_less", int'(less_o), 0);
    repeat (12) @(negedge clk);
    issue(32'h0000_0003, 32'h0000_0009, 1'b0, 1'b1, d); wait_to(d + 1);

    for (int i = 0; i < 150; i++) begin
      ra  = $urandom;
      sel = $urandom_range(0, 3);
      k   = $urandom_range(0, NIB - 1);
      n   = 4'($urandom_range(1, 15));
      case (sel)
        0: rb = ra;
        1: rb = ra ^ (WIDTH'(n) << (4 * k));
        2: rb = $urandom;
        default: rb = {~ra[WIDTH-1], ra[WIDTH-2:0]};
      endcase
      if ($urandom_range(0, 1) == 1) wait_to(d);
      else wait_to(d + 1 + $urandom_range(0, 2));
      issue(ra, rb, 1'($urandom), 1'b1, d);
    end

    t0 = cyc;
    while (q.size() > 0 && cyc < t0 + 50) @(negedge clk);
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    repeat (12) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
